regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters (index 0..NREQ-1); supported range 2..4.
REQ-002 SHALL have parameter OWN_W, default 2, width of o_Owner; SHALL satisfy 2^OWN_W >= NREQ.
REQ-003 SHALL have port i_Clk, input, 1, system clock; all state changes on rising edge.
REQ-004 SHALL have port i_Reset, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port i_Enable, input, 1, system tick; when 0 all internal state holds.
REQ-006 SHALL have port i_Req, input, NREQ, per-requester write request level.
REQ-007 SHALL have port i_Pair, input, NREQ, per-requester: 1 = 16-bit pair write, 0 = 8-bit write.
REQ-008 SHALL have port i_Addr, input, 3*NREQ, per-requester register index (slice k = bits 3k+2:3k); map 0=B 1=C 2=D 3=E 4=H 5=L 6=A 7=F.
REQ-009 SHALL have port i_Data, input, 16*NREQ, per-requester data (slice k = bits 16k+15:16k); 8-bit writes use bits 7:0.
REQ-010 SHALL have port o_Grant, output, NREQ, one-hot completion pulse to the serviced requester.
REQ-011 SHALL have port o_Busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port o_Owner, output, OWN_W, index of the captured requester.
REQ-013 SHALL have port o_RegWrite, output, 8, one-hot write strobe to the eight 8-bit register instances (bit n = index n).
REQ-014 SHALL have port o_RegData, output, 8, byte driven to the register data inputs.

Function
REQ-015 SHALL implement FSM states IDLE, WR_HI, WR_LO; transitions occur only on ticks (i_Enable=1).
REQ-016 In IDLE with any i_Req set, SHALL select a winner, capture its index, i_Pair, i_Addr and i_Data slices into internal registers, and move to WR_HI if pair else WR_LO.
REQ-017 Pair writes SHALL target high index {addr[2:1],0} with data[15:8] in WR_HI, then low index {addr[2:1],1} with data[7:0] in WR_LO; addr[0] ignored.
REQ-018 8-bit writes SHALL target addr with data[7:0] in WR_LO.
REQ-019 WR_HI SHALL go to WR_LO; WR_LO SHALL go to IDLE.
REQ-020 o_RegWrite SHALL be one-hot in WR_HI/WR_LO and all-zero in IDLE; o_RegWrite/o_RegData/o_Grant SHALL decode from registered state only (no combinational path from i_Req).
REQ-021 o_Grant bit of the owner SHALL be high exactly during WR_LO; requester SHALL hold i_Req until it sees o_Grant and drop it the following tick.
REQ-022 Captured operation SHALL complete even if the owner drops i_Req or changes i_Addr/i_Data mid-operation.
REQ-023 Any write to index 7 (F) SHALL force o_RegData[3:0]=0.
REQ-024 Latency: 8-bit write completes 1 tick after capture; pair write 2 ticks; minimum 2 ticks between successive captures.
REQ-025 When i_Enable=0, o_RegWrite SHALL still reflect state (registers gate on their own enable), and no state, pointer or capture SHALL change.

Reset
REQ-026 On i_Reset=1 at a clock edge, regardless of i_Enable: state=IDLE, o_Busy=0, o_Grant=0, o_RegWrite=0, o_RegData=0, o_Owner=0, capture registers=0, RR pointer=NREQ-1.
REQ-027 Reset mid pair write SHALL abandon the low-byte write; an already written high byte is not restored; no o_Grant issued.

Configuration
REQ-028 Macro REGFILE_ARB_ROUND_ROBIN_EN defined: winner is first requester at or after (pointer+1) mod NREQ, pointer updated to owner on entering WR_LO.
REQ-029 Macro REGFILE_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer register exists.

Verification
REQ-030 Reset, tick always 1, i_Req=001, Pair=0, Addr0=6, Data0=0x0042 -> next cycle WR_LO, o_RegWrite=0x40, o_RegData=0x42, o_Grant=001, then IDLE.
REQ-031 i_Req=010, Pair=1, Addr1=5, Data1=0xBEEF -> WR_HI: RegWrite=0x10, Data=0xBE; WR_LO: RegWrite=0x20, Data=0xEF, Grant=010.
REQ-032 Pair write Addr=7, Data=0x12FF -> A gets 0x12 (RegWrite=0x40), F gets 0xF0 (RegWrite=0x80).
REQ-033 i_Req=111 held, each requester drops after its grant then re-raises -> with ROUND_ROBIN_EN grants 0,1,2,0; without, grants 0,0,0.
REQ-034 Pair write, i_Enable=0 for 3 cycles during WR_HI -> state and outputs frozen, resumes to WR_LO on next tick.
REQ-035 i_Reset pulsed during WR_HI -> next cycle IDLE, RegWrite=0, no Grant, Busy=0.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Arbitrates NREQ requesters onto the 8-bit register file, splitting pair writes into high/low byte cycles.
// Optional macro REGFILE_ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed priority.
module regfile_arbiter #(
  parameter int NREQ  = 3,
  parameter int OWN_W = 2
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Enable,
  input  logic [NREQ-1:0]      i_Req,
  input  logic [NREQ-1:0]      i_Pair,
  input  logic [3*NREQ-1:0]    i_Addr,
  input  logic [16*NREQ-1:0]   i_Data,
  output logic [NREQ-1:0]      o_Grant,
  output logic                 o_Busy,
  output logic [OWN_W-1:0]     o_Owner,
  output logic [7:0]           o_RegWrite,
  output logic [7:0]           o_RegData
);

  // state | meaning
  // IDLE  | waiting for a request, capture happens on the leaving tick
  // WR_HI | pair write, high byte to {addr[2:1],0}
  // WR_LO | final byte write, grant pulse to owner
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_HI = 2'd1,
    WR_LO = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [OWN_W-1:0] owner_q;
  logic             cap_pair_q;
  logic [2:0]       cap_addr_q;
  logic [15:0]      cap_data_q;
  logic [OWN_W-1:0] win;
  logic             any_req;
  logic [2:0]       wr_idx;
  logic [7:0]       wr_byte;
  logic             wr_en;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic [OWN_W-1:0] rr_ptr_q;
  int               rr_idx;
  logic             rr_found;

  // Search starts just after the last owner so every requester gets a turn.
  always_comb begin
    win      = '0;
    rr_idx   = 0;
    rr_found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      rr_idx = (int'(rr_ptr_q) + off) % NREQ;
      if (!rr_found && i_Req[rr_idx]) begin
        win      = OWN_W'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_Req[i]) win = OWN_W'(i);
    end
  end
`endif

  assign any_req = |i_Req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = i_Pair[win] ? WR_HI : WR_LO;
      WR_HI:   state_d = WR_LO;
      WR_LO:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      cap_pair_q <= 1'b0;
      cap_addr_q <= 3'd0;
      cap_data_q <= 16'd0;
    end else if (i_Enable) begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        owner_q    <= win;
        cap_pair_q <= i_Pair[win];
        cap_addr_q <= i_Addr[3*win +: 3];
        cap_data_q <= i_Data[16*win +: 16];
      end
    end
  end

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  // Pointer moves when the final byte cycle starts; on a direct 8-bit capture the owner is still the live winner.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      rr_ptr_q <= OWN_W'(NREQ - 1);
    end else if (i_Enable && state_d == WR_LO && state_q != WR_LO) begin
      rr_ptr_q <= (state_q == IDLE) ? win : owner_q;
    end
  end
`endif

  // Outputs come only from registered capture/state, never from the live request inputs.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = 3'd0;
    wr_byte = 8'd0;
    case (state_q)
      WR_HI: begin
        wr_en   = 1'b1;
        wr_idx  = {cap_addr_q[2:1], 1'b0};
        wr_byte = cap_data_q[15:8];
      end
      WR_LO: begin
        wr_en   = 1'b1;
        wr_idx  = cap_pair_q ? {cap_addr_q[2:1], 1'b1} : cap_addr_q;
        wr_byte = cap_data_q[7:0];
      end
      default: begin
        wr_en   = 1'b0;
        wr_idx  = 3'd0;
        wr_byte = 8'd0;
      end
    endcase
    // The flag register has no storage behind its low nibble.
    if (wr_en && wr_idx == 3'd7) wr_byte[3:0] = 4'h0;
  end

  assign o_RegWrite = wr_en ? (8'd1 << wr_idx) : 8'd0;
  assign o_RegData  = wr_byte;
  assign o_Grant    = (state_q == WR_LO) ? (NREQ'(1) << owner_q) : '0;
  assign o_Busy     = (state_q != IDLE);
  assign o_Owner    = owner_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: directed writes push expected strobes, a negedge monitor pops and compares.
module tb_regfile_arbiter;
  localparam int NREQ  = 3;
  localparam int OWN_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [2:0]  req  = '0;
  logic [2:0]  pair = '0;
  logic [8:0]  addr = '0;
  logic [47:0] data = '0;

  logic [2:0]       grant;
  logic             busy;
  logic [OWN_W-1:0] owner;
  logic [7:0]       reg_write;
  logic [7:0]       reg_data;

  logic [18:0] exp_q[$];
  logic [18:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;

  regfile_arbiter #(.NREQ(NREQ), .OWN_W(OWN_W)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
    .i_Req(req), .i_Pair(pair), .i_Addr(addr), .i_Data(data),
    .o_Grant(grant), .o_Busy(busy), .o_Owner(owner),
    .o_RegWrite(reg_write), .o_RegData(reg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] rw, input logic [7:0] rd, input logic [2:0] g);
    exp_q.push_back({rw, rd, g});
  endtask

  task automatic drive(input int k, input logic p, input logic [2:0] a, input logic [15:0] d);
    pair[k]        = p;
    addr[3*k +: 3] = a;
    data[16*k +: 16] = d;
    req[k]         = 1'b1;
  endtask

  // Waits for grant to k, drops its request, returns ticks from request to grant.
  task automatic wait_grant(input int k, output int cycles);
    logic got;
    got    = 1'b0;
    cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (grant[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: requester %0d got no grant, required one", k);
    end
    req[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: each committed write strobe (or grant) must match the next queued expectation.
  always @(negedge clk) begin
    if (en && (reg_write != 8'd0 || grant != 3'd0)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rw=%0h rd=%0h grant=%0h required none", reg_write, reg_data, grant);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_rw_rd_grant", {13'd0, reg_write, reg_data, grant}, {13'd0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    int seq[4];
    logic got;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_regwrite", reg_write, 0);
    check("reset_regdata", reg_data, 0);
    check("reset_grant", grant, 0);
    check("reset_owner", owner, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 8-bit write to A
    drive(0, 1'b0, 3'd6, 16'h0042);
    push(8'h40, 8'h42, 3'b001);
    wait_grant(0, cyc);
    check("lat_8bit", cyc, 1);

    // pair write HL
    drive(1, 1'b1, 3'd5, 16'hBEEF);
    push(8'h10, 8'hBE, 3'b000);
    push(8'h20, 8'hEF, 3'b010);
    wait_grant(1, cyc);
    check("lat_pair", cyc, 2);

    // pair write AF, low nibble of F forced to zero
    drive(2, 1'b1, 3'd7, 16'h12FF);
    push(8'h40, 8'h12, 3'b000);
    push(8'h80, 8'hF0, 3'b100);
    wait_grant(2, cyc);

    // 8-bit write to F
    drive(0, 1'b0, 3'd7, 16'h00AB);
    push(8'h80, 8'hA0, 3'b001);
    wait_grant(0, cyc);

    // owner drops request and scrambles inputs mid pair write
    drive(1, 1'b1, 3'd2, 16'h5678);
    push(8'h04, 8'h56, 3'b000);
    push(8'h08, 8'h78, 3'b010);
    @(posedge clk); #1;
    req[1]        = 1'b0;
    addr[3 +: 3]  = 3'd7;
    data[16 +: 16] = 16'hFFFF;
    check("midop_owner", owner, 1);
    @(posedge clk); #1;
    check("midop_grant", grant, 3'b010);
    @(posedge clk); #1;
    check("midop_idle", busy, 0);

    // tick stalled for 3 cycles during WR_HI
    drive(2, 1'b1, 3'd2, 16'hA55A);
    push(8'h04, 8'hA5, 3'b000);
    push(8'h08, 8'h5A, 3'b100);
    @(posedge clk); #1;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("freeze_rw", reg_write, 8'h04);
      check("freeze_rd", reg_data, 8'hA5);
      check("freeze_busy", busy, 1);
      check("freeze_grant", grant, 0);
    end
    en = 1'b1;
    wait_grant(2, cyc);
    check("freeze_resume_lat", cyc, 1);

    // reset during WR_HI: high byte already written, low byte abandoned
    drive(0, 1'b1, 3'd1, 16'h3344);
    push(8'h01, 8'h33, 3'b000);
    @(posedge clk); #1;
    check("rst_mid_busy_before", busy, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_regwrite", reg_write, 0);
    check("rst_mid_regdata", reg_data, 0);
    check("rst_mid_grant", grant, 0);
    check("rst_mid_owner", owner, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_grant", grant, 0);

    // all three requesting; each drops for one tick after its grant
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 2, 0};
`else
    seq = '{0, 0, 0, 0};
`endif
    for (int j = 0; j < 3; j++) begin
      pair[j]          = 1'b0;
      addr[3*j +: 3]   = 3'(j);
      data[16*j +: 16] = 16'h0010 + 16'(j);
    end
    for (int g = 0; g < 4; g++) push(8'd1 << seq[g], 8'h10 + 8'(seq[g]), 3'd1 << seq[g]);
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (grant != 3'd0) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL arb_timeout: no grant for round %0d, required one", g);
        break;
      end
      k = 0;
      for (int b = 0; b < 3; b++) if (grant[b]) k = b;
      check("arb_order", k, seq[g]);
      if (g < 3) begin
        req[k] = 1'b0;
        @(posedge clk); #1;
        req[k] = 1'b1;
      end else begin
        req = '0;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("final_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
